ysyx_22041207_axi_rd_bridge: RTL
================================

# ysyx_22041207_axi_rd_bridge

Read-side AXI4 master bridge: the responder on the simple read interface (`valid/ready/addr/size` request, `data_valid/data_ready` response) that the IF/MEM read arbiter drives. It accepts one request at a time, issues a single-beat AXI4 AR transaction, and collects the R beat. It returns byte-aligned, zero-masked read data to the arbiter and holds it until consumed. It sits between the read arbiter and the SoC AXI interconnect.

## Interface
- `RW_DATA_WIDTH`, 64, simple-side data width
- `RW_ADDR_WIDTH`, 64, simple-side address width
- `AXI_DATA_WIDTH`, 64, AXI R data width; must equal RW_DATA_WIDTH
- `AXI_ADDR_WIDTH`, 64, AXI AR address width
- `AXI_ID_WIDTH`, 4, AXI ID width
- `AXI_USER_WIDTH`, 1, AXI user width
- `AXI_ID`, 0, constant ARID driven on every request

Ports:
- `clk` in 1: single clock; all logic on posedge
- `rst_n` in 1: asynchronous, active-low reset
- `r_valid_i` in 1: request valid
- `r_ready_o` out 1: request accepted (handshake when both high)
- `r_addr_i` in RW_ADDR_WIDTH: byte address
- `r_size_i` in 8: access size in bytes (1, 2, 4, 8)
- `r_data_o` out RW_DATA_WIDTH: aligned, zero-masked read data
- `r_data_valid_o` out 1: response valid
- `r_data_ready_i` in 1: response consumed
- `r_err_o` out 1: response carried SLVERR/DECERR; valid with r_data_valid_o
- `axi_ar_valid_o`/`axi_ar_ready_i` out/in 1: AR handshake
- `axi_ar_addr_o` out AXI_ADDR_WIDTH; `axi_ar_id_o` out AXI_ID_WIDTH; `axi_ar_len_o` out 8; `axi_ar_size_o` out 3; `axi_ar_burst_o` out 2; `axi_ar_user_o` out AXI_USER_WIDTH
- `axi_r_valid_i`/`axi_r_ready_o` in/out 1: R handshake
- `axi_r_data_i` in AXI_DATA_WIDTH; `axi_r_resp_i` in 2; `axi_r_last_i` in 1; `axi_r_id_i` in AXI_ID_WIDTH; `axi_r_user_i` in AXI_USER_WIDTH

## Operation
- FSM states: IDLE, AR, R, DONE. Reset → IDLE.
- IDLE: `r_ready_o`=1. On `r_valid_i`: latch addr and size → AR.
- AR: `axi_ar_valid_o`=1 with ARADDR=latched addr, ARLEN=0, ARBURST=INCR (2'b01), ARID=AXI_ID, ARUSER=0. ARSIZE: size 1→0, 2→1, 4→2, 8→3, any other value→3. Payload stable while valid. On `axi_ar_ready_i` → R.
- R: `axi_r_ready_o`=1. The first beat with `axi_r_valid_i` is latched as data. Responses of 2'b10/2'b11 on any beat are OR-ed into the error flag. The FSM stays in R until a beat with `axi_r_last_i`, then goes → DONE. Extra beats are drained and discarded. RID/RUSER are ignored.
- DONE: `r_data_valid_o`=1, `r_data_o` and `r_err_o` stable. On `r_data_ready_i` → IDLE.
- Data alignment: out = beat >> (addr[2:0]*8), then bytes at index ≥ size are zeroed. Size ≥8 or illegal passes all 8 bytes. Unaligned access: bytes shifted past the beat read as zero. There is no sign extension.
- Outputs are zero whenever not qualified by their state: `r_data_o`=0 outside DONE, `axi_ar_*` payload=0 outside AR.

## Timing
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- Reset values: every output 0 except `r_ready_o`=1 (IDLE). Error flag and data register are cleared.
- Minimum latency: request accepted in cycle T; ARVALID at T+1; with ARREADY at T+1 and RVALID+RLAST at T+2, `r_data_valid_o` rises at T+3.
- `r_ready_o` is low from T+1 until the cycle after the response handshake, so only one outstanding request. The next request is accepted at the earliest the cycle after DONE exits.
- `r_data_valid_o` holds indefinitely until `r_data_ready_i`. It drops the cycle after the handshake.
- RVALID arriving while in AR is not accepted, because RREADY=0.
- Reset mid-operation: immediate return to IDLE and reset outputs. An in-flight AXI transaction is abandoned, since reset is system-wide.

## Structure
- Shared package `ysyx_22041207_axi_pkg` holds:
  - AXI constants: BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR
  - the FSM state enum
  - the bytes→ARSIZE encode function
- Sub-module `ysyx_22041207_rdata_align` is purely combinational. It takes beat, addr[2:0] and size, and produces the aligned, masked data. It is used in the R-state capture path.

## Test plan
- Size 8 at addr 0x8000_0000, RDATA 0x1122334455667788 OKAY LAST, immediate ARREADY → ARSIZE=3, ARLEN=0, `r_data_o`=0x1122334455667788, data_valid at T+3, `r_err_o`=0.
- Size 2 at 0x8000_0006, same RDATA → ARSIZE=1, `r_data_o`=0x0000000000001122.
- ARREADY delayed 5 cycles, RVALID delayed 3 more → ARVALID and payload held 6 cycles, RREADY held until the beat, data correct.
- `r_data_ready_i` held low 10 cycles → data_valid and data stable for all 10 cycles, `r_ready_o`=0 throughout, returns to IDLE one cycle after ready.
- RRESP=2'b10 on a 2-beat response (first beat not LAST) → data from the first beat, `r_err_o`=1, DONE only after LAST.
- `rst_n` pulsed low while in AR and while in DONE → all outputs go to reset values asynchronously, `r_ready_o`=1 after release, next request completes normally.

Source files
------------

// File: rtl/ysyx_22041207_axi_pkg.sv
// Shared AXI4 read-bridge definitions: protocol constants, FSM state type and
// the byte-count to ARSIZE encoding.
package ysyx_22041207_axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } rd_state_e;

  // Unknown sizes fall back to a full 8-byte beat.
  function automatic logic [2:0] bytes_to_arsize(input logic [7:0] bytes);
    case (bytes)
      8'd1:    return 3'd0;
      8'd2:    return 3'd1;
      8'd4:    return 3'd2;
      default: return 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22041207_rdata_align.sv
// Combinational read-data aligner: shifts the beat down to the requested byte
// offset and zeroes every byte beyond the access size.
module ysyx_22041207_rdata_align #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] beat_i,
  input  logic [2:0]        offset_i,
  input  logic [7:0]        size_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;

  always_comb begin
    shifted = beat_i >> {offset_i, 3'b000};
    case (size_i)
      8'd1:    mask = {{(DATA_W-8){1'b0}},  8'hFF};
      8'd2:    mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
      8'd4:    mask = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
      default: mask = '1;
    endcase
    data_o = shifted & mask;
  end

endmodule

// File: rtl/ysyx_22041207_axi_rd_bridge.sv
// Single-outstanding read bridge from the simple read interface to an AXI4
// master read channel; returns aligned, zero-masked data held until consumed.
module ysyx_22041207_axi_rd_bridge
  import ysyx_22041207_axi_pkg::*;
#(
  parameter int RW_DATA_WIDTH  = 64,
  parameter int RW_ADDR_WIDTH  = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 1,
  parameter int AXI_ID         = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  input  logic [RW_ADDR_WIDTH-1:0]  r_addr_i,
  input  logic [7:0]                r_size_i,
  output logic [RW_DATA_WIDTH-1:0]  r_data_o,
  output logic                      r_data_valid_o,
  input  logic                      r_data_ready_i,
  output logic                      r_err_o,
  output logic                      axi_ar_valid_o,
  input  logic                      axi_ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_ar_id_o,
  output logic [7:0]                axi_ar_len_o,
  output logic [2:0]                axi_ar_size_o,
  output logic [1:0]                axi_ar_burst_o,
  output logic [AXI_USER_WIDTH-1:0] axi_ar_user_o,
  input  logic                      axi_r_valid_i,
  output logic                      axi_r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0] axi_r_data_i,
  input  logic [1:0]                axi_r_resp_i,
  input  logic                      axi_r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_r_id_i,
  input  logic [AXI_USER_WIDTH-1:0] axi_r_user_i
);

  rd_state_e                state_q, state_d;
  logic [RW_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]               size_q;
  logic [RW_DATA_WIDTH-1:0] data_q;
  logic [RW_DATA_WIDTH-1:0] aligned;
  logic                     err_q;
  logic                     beat_seen_q;
  logic                     accept;
  logic                     r_beat;
  logic                     unused_inputs;

  assign accept        = (state_q == ST_IDLE) && r_valid_i;
  assign r_beat        = (state_q == ST_R) && axi_r_valid_i;
  assign unused_inputs = ^{axi_r_id_i, axi_r_user_i, axi_r_resp_i[0]};

  ysyx_22041207_rdata_align #(
    .DATA_W (RW_DATA_WIDTH)
  ) u_align (
    .beat_i   (RW_DATA_WIDTH'(axi_r_data_i)),
    .offset_i (addr_q[2:0]),
    .size_i   (size_q),
    .data_o   (aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Only the first beat is captured; later beats of a burst merely add errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      size_q      <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      beat_seen_q <= 1'b0;
    end else if (accept) begin
      addr_q      <= r_addr_i;
      size_q      <= r_size_i;
      err_q       <= 1'b0;
      beat_seen_q <= 1'b0;
    end else if (r_beat) begin
      beat_seen_q <= 1'b1;
      if (!beat_seen_q) data_q <= aligned;
      if (axi_r_resp_i[1]) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    r_ready_o      = 1'b0;
    r_data_o       = '0;
    r_data_valid_o = 1'b0;
    r_err_o        = 1'b0;
    axi_ar_valid_o = 1'b0;
    axi_ar_addr_o  = '0;
    axi_ar_id_o    = '0;
    axi_ar_len_o   = '0;
    axi_ar_size_o  = '0;
    axi_ar_burst_o = '0;
    axi_ar_user_o  = '0;
    axi_r_ready_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        r_ready_o = 1'b1;
        if (r_valid_i) state_d = ST_AR;
      end
      ST_AR: begin
        axi_ar_valid_o = 1'b1;
        axi_ar_addr_o  = AXI_ADDR_WIDTH'(addr_q);
        axi_ar_id_o    = AXI_ID_WIDTH'(AXI_ID);
        axi_ar_size_o  = bytes_to_arsize(size_q);
        axi_ar_burst_o = BURST_INCR;
        if (axi_ar_ready_i) state_d = ST_R;
      end
      ST_R: begin
        axi_r_ready_o = 1'b1;
        if (axi_r_valid_i && axi_r_last_i) state_d = ST_DONE;
      end
      ST_DONE: begin
        r_data_valid_o = 1'b1;
        r_data_o       = data_q;
        r_err_o        = err_q;
        if (r_data_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
